// File: rtl/serial_add_sequencer_pkg.sv
// serial_add_pkg: shared types and helpers for the serial add sequencer.
//   state_t - sequencer FSM states
//   cnt_w   - bit-counter width for a given operand width
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach width-1, so $clog2(width) bits suffice.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if: operand and result handshakes of the serial add sequencer.
//   in_valid/in_ready   - operand pair handshake (a, b, sub)
//   out_valid/out_ready - result handshake (sum, carry_out, overflow)
//   master - producer/consumer side, slave - sequencer side
interface serial_add_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_adder_cell.sv
// serial_adder_cell: 1-bit full adder with a registered carry.
//   clk, rst  - clock, asynchronous active-high reset
//   en        - advance the carry by one bit position
//   load      - overwrite the carry with load_val (priority over en)
//   a, b      - operand bits for the current position
//   sum       - combinational sum bit of a, b and the current carry
//   carry     - current carry (carry into this bit position)
module serial_adder_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  logic load_val,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    logic carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (load) begin
            carry_q <= load_val;
        end else if (en) begin
            carry_q <= (a & b) | (carry_q & (a ^ b));
        end
    end

    assign sum   = a ^ b ^ carry_q;
    assign carry = carry_q;

endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: word-level add/subtract built on a 1-bit serial adder.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of serial_add_sequencer_if: accepts {a, b, sub}, returns
//              {sum, carry_out, overflow} WIDTH cycles later, held until out_ready.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_add_sequencer_if.slave bus
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic accept;
    logic sum_bit;
    logic c_cur;
    logic c_fin;

    assign accept = (state_q == IDLE) && bus.in_valid && in_ready_q;

    serial_adder_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == RUN),
        .load     (accept),
        .load_val (bus.sub),
        .a        (a_sh_q[0]),
        .b        (b_sh_q[0]),
        .sum      (sum_bit),
        .carry    (c_cur)
    );

    // Carry out of the bit being processed; on the last bit this is the MSB carry-out.
    assign c_fin = (a_sh_q[0] & b_sh_q[0]) | (c_cur & (a_sh_q[0] ^ b_sh_q[0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh_q     <= bus.a;
                        b_sh_q     <= bus.sub ? ~bus.b : bus.b;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    // After WIDTH shifts the first (LSB) sum bit lands in bit 0.
                    res_q  <= {sum_bit, res_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        carry_out_q <= c_fin;
                        // c_cur is the carry into the MSB here.
                        overflow_q  <= c_cur ^ c_fin;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // in_ready resets to 1 but must read 0 while rst is held.
    assign bus.in_ready  = in_ready_q & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = res_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed and random checks of serial_add_sequencer (WIDTH=8).
module tb_serial_add_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    serial_add_sequencer_if #(.WIDTH(8)) bus ();

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for in_ready, present one operand pair for exactly one accept edge.
    task automatic send(input logic [7:0] a_v, input logic [7:0] b_v, input logic s_v);
        int k;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.a        = a_v;
        bus.b        = b_v;
        bus.sub      = s_v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid rises (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) check("out_valid_timeout", 0, 1);
    endtask

    // Check result, hold it under backpressure for 'stall' cycles, then hand it off.
    task automatic take(input string tag, input logic [7:0] es, input logic ec,
                        input logic eo, input int stall);
        check({tag, "_sum"}, bus.sum, es);
        check({tag, "_carry"}, bus.carry_out, ec);
        check({tag, "_ovf"}, bus.overflow, eo);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_sum"}, bus.sum, es);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, bus.out_valid, 0);
    endtask

    task automatic directed(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                            input logic s_v, input logic [7:0] es, input logic ec,
                            input logic eo);
        int lat;
        send(a_v, b_v, s_v);
        wait_out(lat);
        check({tag, "_latency"}, lat, 8);
        take(tag, es, ec, eo, 0);
    endtask

    initial begin
        int          lat;
        logic [7:0]  ra, rb, beff;
        logic        rs;
        logic [8:0]  full;
        logic        rov;

        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;

        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_carry", bus.carry_out, 0);
        check("rst_ovf", bus.overflow, 0);
        #9;
        rst = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1);

        directed("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure: new operands offered during DONE must wait.
        send(8'h35, 8'h4A, 1'b0);
        wait_out(lat);
        check("bp_latency", lat, 8);
        bus.a        = 8'h11;
        bus.b        = 8'h22;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_sum", bus.sum, 8'h7F);
            check("bp_carry", bus.carry_out, 0);
            check("bp_ovf", bus.overflow, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_valid_drop", bus.out_valid, 0);
        check("bp_idle_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_accepted", bus.in_ready, 0);
        wait_out(lat);
        check("bp2_latency", lat, 8);
        take("bp2", 8'h33, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of an operation.
        send(8'hFF, 8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_rel_ready", bus.in_ready, 1);
        check("arst_rel_valid", bus.out_valid, 0);
        directed("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Random operations against a word-level model.
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rs   = 1'($urandom);
            beff = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, beff} + {8'b0, rs};
            rov  = (ra[7] == beff[7]) && (full[7] != ra[7]);
            send(ra, rb, rs);
            wait_out(lat);
            check("rnd_latency", lat, 8);
            take("rnd", full[7:0], full[8], rov, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
